// File: rtl/zero_run_scanner_if.sv
// Handshake bundle for zero_run_scanner: request side (word, direction,
// polarity) and result side (run length, all-match flag).
interface zero_run_scanner_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = $clog2(IN_W + 1)
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in;
   logic             dir;
   logic             polarity;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out;
   logic             all_match;

   // Requester / result consumer side
   modport master (
      output in_valid, in, dir, polarity, out_ready,
      input  in_ready, out_valid, out, all_match
   );

   // Scanner side
   modport slave (
      input  in_valid, in, dir, polarity, out_ready,
      output in_ready, out_valid, out, all_match
   );
endinterface

// File: rtl/zero_run_scanner.sv
// zero_run_scanner: multi-cycle run-length counter. Counts the run of 0s or 1s
// at the MSB (dir=0) or LSB (dir=1) end of an IN_W-bit word, CHUNK_W bits per
// clock. The word is inverted on capture when counting 1s, so the scan datapath
// only ever counts zeros.
// Optional build macro: ZERO_RUN_EARLY_EXIT_EN -- leave SCAN as soon as a
// chunk is not entirely zero instead of always walking all NCHUNK chunks.
// Results are identical either way; only latency differs.
module zero_run_scanner #(
   parameter int IN_W    = 32,
   parameter int CHUNK_W = 8,
   parameter int OUT_W   = $clog2(IN_W + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   zero_run_scanner_if.slave    bus
);

   localparam int NCHUNK = IN_W / CHUNK_W;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CW     = $clog2(CHUNK_W + 1);
   localparam int SH_W   = $clog2(IN_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [IN_W-1:0]  r_word;
   logic             r_dir;
   logic [OUT_W-1:0] r_acc;
   logic [IDX_W-1:0] r_idx;
   logic             r_broken;
   logic [OUT_W-1:0] r_out;
   logic             r_all_match;
   logic             r_out_valid;
   logic             r_in_ready;

   logic [SH_W-1:0]    w_shamt;
   logic [IN_W-1:0]    w_shifted;
   logic [CHUNK_W-1:0] w_chunk;
   logic [CHUNK_W-1:0] w_ord;
   logic [CW-1:0]      w_run;
   logic               w_hit;
   logic               w_full;
   logic               w_last;
   logic               w_exit;
   logic [OUT_W-1:0]   w_acc_nxt;

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.all_match = r_all_match;

   // Bring the current chunk to a fixed position: LSB end for trailing scans,
   // MSB end for leading scans.
   assign w_shamt   = SH_W'(r_idx) * SH_W'(CHUNK_W);
   assign w_shifted = r_dir ? (r_word >> w_shamt) : (r_word << w_shamt);
   assign w_chunk   = r_dir ? w_shifted[CHUNK_W-1:0] : w_shifted[IN_W-1 -: CHUNK_W];

   // Order chunk bits so index 0 is always the scan-side edge.
   always_comb begin
      w_ord = w_chunk;
      if (!r_dir) begin
         for (int i = 0; i < CHUNK_W; i++) w_ord[i] = w_chunk[CHUNK_W-1-i];
      end
   end

   // Zero run inside the chunk, starting at the scan-side edge.
   always_comb begin
      w_run = '0;
      w_hit = 1'b0;
      for (int i = 0; i < CHUNK_W; i++) begin
         if (!w_hit) begin
            if (w_ord[i]) w_hit = 1'b1;
            else          w_run = w_run + CW'(1);
         end
      end
   end

   assign w_full    = (w_run == CW'(CHUNK_W));
   assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));
   assign w_acc_nxt = r_broken ? r_acc : (r_acc + OUT_W'(w_run));

`ifdef ZERO_RUN_EARLY_EXIT_EN
   assign w_exit = w_last || (!r_broken && !w_full);
`else
   assign w_exit = w_last;
`endif

   // Control FSM with registered handshake and result outputs. in_ready stays
   // low through reset and rises on the first edge after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_word      <= '0;
         r_dir       <= 1'b0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_broken    <= 1'b0;
         r_out       <= '0;
         r_all_match <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b1;
               if (bus.in_valid && r_in_ready) begin
                  r_word     <= bus.in ^ {IN_W{bus.polarity}};
                  r_dir      <= bus.dir;
                  r_acc      <= '0;
                  r_idx      <= '0;
                  r_broken   <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_acc <= w_acc_nxt;
               if (!r_broken && !w_full) r_broken <= 1'b1;
               if (w_exit) begin
                  r_out       <= w_acc_nxt;
                  r_all_match <= (w_acc_nxt == OUT_W'(IN_W));
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zero_run_scanner.sv
// Self-checking bench for zero_run_scanner (IN_W=32, CHUNK_W=8): directed
// vectors, output stall, mid-scan reset, back-to-back throughput and random
// words against a bit-walking reference model.
module tb_zero_run_scanner;

   localparam int IN_W    = 32;
   localparam int CHUNK_W = 8;
   localparam int NCHUNK  = IN_W / CHUNK_W;
   localparam int OUT_W   = $clog2(IN_W + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   zero_run_scanner_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   zero_run_scanner #(.IN_W(IN_W), .CHUNK_W(CHUNK_W), .OUT_W(OUT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: walk bits from the chosen end while they equal the polarity.
   function automatic int ref_run(input logic [31:0] w, input logic d, input logic p);
      int n = 0;
      for (int i = 0; i < IN_W; i++) begin
         int b = d ? i : (IN_W - 1 - i);
         if (w[b] !== p) break;
         n++;
      end
      return n;
   endfunction

   // Cycles from the accept cycle to the first cycle showing out_valid.
   function automatic int ref_lat(input int n);
`ifdef ZERO_RUN_EARLY_EXIT_EN
      int k = n / CHUNK_W + 1;
      if (k > NCHUNK) k = NCHUNK;
      return k + 1;
`else
      return NCHUNK + 1;
`endif
   endfunction

   // Issue one request, stall the result for 'stall' cycles, return first and
   // last observed result plus latency.
   task automatic do_req(input logic [31:0] w, input logic d, input logic p, input int stall,
                         output int o, output logic am, output int o2, output int lat);
      int guard = 0;
      while (!bus.in_ready && guard < 100) begin @(negedge clk); guard++; end
      if (guard >= 100) begin
         checks++; errors++;
         $display("FAIL req_in_ready_timeout: in_ready=%0b required 1", bus.in_ready);
      end
      bus.in_valid  = 1'b1;
      bus.in        = w;
      bus.dir       = d;
      bus.polarity  = p;
      bus.out_ready = (stall == 0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.in_valid = 1'b0;
         bus.in       = $urandom;
         bus.dir      = 1'($urandom);
         bus.polarity = 1'($urandom);
      end while (!bus.out_valid && lat < 100);
      o  = int'(bus.out);
      am = bus.all_match;
      repeat (stall) @(negedge clk);
      o2 = int'(bus.out);
      bus.out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 0 0", bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.out !== '0 || bus.all_match !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: out=%0d all_match=%0b required 0 0", bus.out, bus.all_match);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: in_ready=%0b required 1", bus.in_ready);
      end
   endtask

   task automatic test_directed();
      logic [31:0] wv [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0001_0000,
                              32'hFFFF_FF00, 32'hFFFF_FF00, 32'h8000_0000};
      logic        dv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        pv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int          ev [6] = '{32, 15, 16, 24, 8, 0};
      int o, o2, lat;
      logic am;
      for (int t = 0; t < 6; t++) begin
         do_req(wv[t], dv[t], pv[t], 0, o, am, o2, lat);
         checks++;
         if (o !== ev[t] || am !== (ev[t] == IN_W)) begin
            errors++;
            $display("FAIL directed_%0d: out=%0d all_match=%0b required %0d %0b",
                     t, o, am, ev[t], (ev[t] == IN_W));
         end
         checks++;
         if (lat !== ref_lat(ev[t])) begin
            errors++;
            $display("FAIL directed_lat_%0d: latency=%0d required %0d", t, lat, ref_lat(ev[t]));
         end
      end
   endtask

   task automatic test_stall();
      int lat = 0;
      bus.in_valid = 1'b1; bus.in = 32'h0001_0000; bus.dir = 1'b0; bus.polarity = 1'b0;
      bus.out_ready = 1'b0;
      do begin @(negedge clk); lat++; bus.in_valid = 1'b0; end
      while (!bus.out_valid && lat < 100);
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out !== 6'd15 || bus.in_ready !== 1'b0 || bus.all_match !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold_%0d: out_valid=%0b out=%0d in_ready=%0b all_match=%0b required 1 15 0 0",
                     c, bus.out_valid, bus.out, bus.in_ready, bus.all_match);
         end
         bus.in_valid = ~bus.in_valid;
         bus.in       = $urandom;
         bus.polarity = 1'($urandom);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 6'd15) begin
         errors++;
         $display("FAIL stall_release: out_valid=%0b in_ready=%0b out=%0d required 0 1 15",
                  bus.out_valid, bus.in_ready, bus.out);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_no_capture: out_valid=%0b in_ready=%0b required 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid_scan();
      int o, o2, lat;
      logic am;
      bus.in_valid = 1'b1; bus.in = 32'h0000_0000; bus.dir = 1'b0; bus.polarity = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_%0d: out_valid=%0b in_ready=%0b required 0 0", c, bus.out_valid, bus.in_ready);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_release: in_ready=%0b out_valid=%0b required 1 0", bus.in_ready, bus.out_valid);
      end
      do_req(32'h0000_00FF, 1'b1, 1'b1, 0, o, am, o2, lat);
      checks++;
      if (o !== 8 || am !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_next: out=%0d all_match=%0b required 8 0", o, am);
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc [$];
      int results = 0;
      int exp_per = ref_lat(8) + 1;
      bus.in_valid = 1'b1; bus.in = 32'h00FF_0000; bus.dir = 1'b0; bus.polarity = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4 * (NCHUNK + 2); c++) begin
         if (bus.in_valid && bus.in_ready) acc_cyc.push_back(c);
         if (bus.out_valid) begin
            results++;
            checks++;
            if (bus.out !== 6'd8) begin
               errors++;
               $display("FAIL b2b_out: out=%0d required 8", bus.out);
            end
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      checks++;
      if (acc_cyc.size() < 3) begin
         errors++;
         $display("FAIL b2b_accepts: accepted=%0d required >=3", acc_cyc.size());
      end else begin
         for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== exp_per) begin
               errors++;
               $display("FAIL b2b_period: period=%0d required %0d", acc_cyc[i] - acc_cyc[i-1], exp_per);
            end
         end
      end
      repeat (2 * (NCHUNK + 2)) @(negedge clk);
      bus.out_ready = 1'b1;
   endtask

   task automatic test_random();
      int o, o2, lat, n, exp, stall;
      logic am, d, p;
      logic [31:0] w, m;
      for (int t = 0; t < 300; t++) begin
         d = 1'($urandom);
         p = 1'($urandom);
         n = $urandom_range(0, IN_W);
         w = $urandom;
         // Plant a run of n polarity bits at the scan end for coverage of long runs.
         m = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
         if (!d) m = {<<{m}};
         if ($urandom_range(0, 3) != 0) w = p ? (w | m) : (w & ~m);
         exp   = ref_run(w, d, p);
         stall = $urandom_range(0, 2);
         do_req(w, d, p, stall, o, am, o2, lat);
         checks++;
         if (o !== exp || am !== (exp == IN_W) || o2 !== exp) begin
            errors++;
            $display("FAIL random_%0d: w=%h dir=%0b pol=%0b out=%0d/%0d all_match=%0b required %0d %0b",
                     t, w, d, p, o, o2, am, exp, (exp == IN_W));
         end
         checks++;
         if (lat !== ref_lat(exp)) begin
            errors++;
            $display("FAIL random_lat_%0d: latency=%0d required %0d", t, lat, ref_lat(exp));
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in        = '0;
      bus.dir       = 1'b0;
      bus.polarity  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_directed();
      test_stall();
      test_reset_mid_scan();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
